// File: rtl/pipe_pkg.sv
// Shared types and control-bundle layout for the pipeline stage registers.
// Used by pipe_stage_reg; the skid buffer is enabled with PIPE_STAGE_SKID_EN.
package pipe_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FULL  = 2'd1,
      SKID  = 2'd2
   } pipe_state_t;

   // ID/EX control bundle layout
   localparam int CTRL_W_IDEX  = 8;
   localparam int ALUOP_LSB    = 0;
   localparam int ALUOP_W      = 2;
   localparam int ALUSRC_BIT   = 2;
   localparam int BRANCH_BIT   = 3;
   localparam int MEMREAD_BIT  = 4;
   localparam int MEMWRITE_BIT = 5;
   localparam int REGWRITE_BIT = 6;
   localparam int MEMTOREG_BIT = 7;

   function automatic logic is_stall(input logic valid, input logic ready);
      return valid & ~ready;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count <= '0;
      end else if (inc && (count != {CNT_W{1'b1}})) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline stage register with flush, control zeroing and stall counter.
// Define PIPE_STAGE_SKID_EN to add a second (skid) entry and a registered in_ready_o.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int DATA_W = 128,
   parameter int CTRL_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [DATA_W-1:0] in_data_i,
   input  logic [CTRL_W-1:0] in_ctrl_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [DATA_W-1:0] out_data_o,
   output logic [CTRL_W-1:0] out_ctrl_o,
   input  logic              flush_i,
   output logic [CNT_W-1:0]  stall_cnt_o,
   input  logic              stall_cnt_clr_i,
   output pipe_state_t       state_o
);

   // Handshake: a bundle moves on a port in any cycle where valid and ready are
   // both high at the rising edge; valid must not depend on ready.
   pipe_state_t       state;
   logic [DATA_W-1:0] main_data;
   logic [CTRL_W-1:0] main_ctrl;
   logic              in_fire;
   logic              out_fire;

   assign out_valid_o = (state != EMPTY);
   assign out_data_o  = main_data;
   assign out_ctrl_o  = main_ctrl;
   assign state_o     = state;
   assign in_fire     = in_valid_i & in_ready_o;
   assign out_fire    = out_valid_o & out_ready_i;

`ifdef PIPE_STAGE_SKID_EN
   logic [DATA_W-1:0] skid_data;
   logic [CTRL_W-1:0] skid_ctrl;

   // Ready comes only from registered state; rst_i gating keeps it low in reset.
   assign in_ready_o = !rst_i && (state != SKID);
`else
   assign in_ready_o = !rst_i && (!out_valid_o || out_ready_i);
`endif

   // Control of an empty entry is always zeroed so a bubble never carries writes.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state     <= EMPTY;
         main_data <= '0;
         main_ctrl <= '0;
`ifdef PIPE_STAGE_SKID_EN
         skid_data <= '0;
         skid_ctrl <= '0;
`endif
      end else if (flush_i) begin
         state     <= EMPTY;
         main_ctrl <= '0;
`ifdef PIPE_STAGE_SKID_EN
         skid_ctrl <= '0;
`endif
      end else begin
         case (state)
            EMPTY: begin
               if (in_fire) begin
                  state     <= FULL;
                  main_data <= in_data_i;
                  main_ctrl <= in_ctrl_i;
               end
            end
            FULL: begin
               if (in_fire && out_fire) begin
                  main_data <= in_data_i;
                  main_ctrl <= in_ctrl_i;
`ifdef PIPE_STAGE_SKID_EN
               end else if (in_fire) begin
                  state     <= SKID;
                  skid_data <= in_data_i;
                  skid_ctrl <= in_ctrl_i;
`endif
               end else if (out_fire) begin
                  state     <= EMPTY;
                  main_ctrl <= '0;
               end
            end
`ifdef PIPE_STAGE_SKID_EN
            SKID: begin
               if (out_fire) begin
                  state     <= FULL;
                  main_data <= skid_data;
                  main_ctrl <= skid_ctrl;
                  skid_ctrl <= '0;
               end
            end
`endif
            default: begin
               state     <= EMPTY;
               main_ctrl <= '0;
            end
         endcase
      end
   end

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_stall_cnt (
      .clk   (clk_i),
      .rst   (rst_i),
      .inc   (is_stall(out_valid_o, out_ready_i)),
      .clr   (stall_cnt_clr_i),
      .count (stall_cnt_o)
   );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg; follows PIPE_STAGE_SKID_EN when defined.
module tb_pipe_stage_reg;
   import pipe_pkg::*;

   localparam int DW = 16;
   localparam int CW = 8;
   localparam int NW = 4;
   localparam int CNT_MAX = 15;
`ifdef PIPE_STAGE_SKID_EN
   localparam bit SKID_EN = 1'b1;
`else
   localparam bit SKID_EN = 1'b0;
`endif

   logic          clk;
   logic          rst_i;
   logic          in_valid_i;
   logic          in_ready_o;
   logic [DW-1:0] in_data_i;
   logic [CW-1:0] in_ctrl_i;
   logic          out_valid_o;
   logic          out_ready_i;
   logic [DW-1:0] out_data_o;
   logic [CW-1:0] out_ctrl_o;
   logic          flush_i;
   logic [NW-1:0] stall_cnt_o;
   logic          stall_cnt_clr_i;
   pipe_state_t   state_o;

   int n_checks = 0;
   int n_fails  = 0;
   int cnt_m    = 0;
   logic [DW+CW-1:0] exp_q[$];

   pipe_stage_reg #(
      .DATA_W (DW),
      .CTRL_W (CW),
      .CNT_W  (NW)
   ) dut (
      .clk_i           (clk),
      .rst_i           (rst_i),
      .in_valid_i      (in_valid_i),
      .in_ready_o      (in_ready_o),
      .in_data_i       (in_data_i),
      .in_ctrl_i       (in_ctrl_i),
      .out_valid_o     (out_valid_o),
      .out_ready_i     (out_ready_i),
      .out_data_o      (out_data_o),
      .out_ctrl_o      (out_ctrl_o),
      .flush_i         (flush_i),
      .stall_cnt_o     (stall_cnt_o),
      .stall_cnt_clr_i (stall_cnt_clr_i),
      .state_o         (state_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   // One clock cycle: drive, check against the model, update the model, pass the edge.
   task automatic step(input logic rst, input logic vld, input logic [DW-1:0] d,
                       input logic [CW-1:0] c, input logic ordy, input logic fl,
                       input logic clr, output logic fired);
      logic [DW+CW-1:0] e;
      logic             exp_rdy;
      int               sz;
      rst_i           = rst;
      in_valid_i      = vld;
      in_data_i       = d;
      in_ctrl_i       = c;
      out_ready_i     = ordy;
      flush_i         = fl;
      stall_cnt_clr_i = clr;
      #1;
      sz = exp_q.size();
      if (rst)          exp_rdy = 1'b0;
      else if (SKID_EN) exp_rdy = (sz < 2);
      else              exp_rdy = (sz == 0) || ordy;
      check_eq("in_ready", 32'(in_ready_o), 32'(exp_rdy));
      check_eq("out_valid", 32'(out_valid_o), 32'(sz != 0));
      check_eq("state", 32'(state_o), (sz == 0) ? 32'(EMPTY) : (sz == 1) ? 32'(FULL) : 32'(SKID));
      check_eq("stall_cnt", 32'(stall_cnt_o), 32'(cnt_m));
      if (!out_valid_o) check_eq("bubble_ctrl", 32'(out_ctrl_o), 32'd0);
      fired = vld & in_ready_o;
      if (rst) begin
         exp_q.delete();
         cnt_m = 0;
      end else begin
         if (out_valid_o && ordy && sz > 0) begin
            e = exp_q.pop_front();
            check_eq("out_data", 32'(out_data_o), 32'(e[DW+CW-1:CW]));
            check_eq("out_ctrl", 32'(out_ctrl_o), 32'(e[CW-1:0]));
         end
         if (fl) exp_q.delete();
         else if (fired) exp_q.push_back({d, c});
         if (clr) cnt_m = 0;
         else if (sz != 0 && !ordy && cnt_m < CNT_MAX) cnt_m++;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic f;
      logic c_sent;
      rst_i = 1'b1; in_valid_i = 1'b0; in_data_i = '0; in_ctrl_i = '0;
      out_ready_i = 1'b0; flush_i = 1'b0; stall_cnt_clr_i = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_valid", 32'(out_valid_o), 32'd0);
      check_eq("rst_data", 32'(out_data_o), 32'd0);
      check_eq("rst_ctrl", 32'(out_ctrl_o), 32'd0);
      check_eq("rst_cnt", 32'(stall_cnt_o), 32'd0);
      check_eq("rst_ready", 32'(in_ready_o), 32'd0);
      check_eq("rst_state", 32'(state_o), 32'(EMPTY));

      // Back-to-back stream 1..5
      for (int i = 1; i <= 5; i++) step(0, 1, DW'(i), CW'(i + 8'h10), 1, 0, 0, f);
      for (int i = 0; i < 2; i++) step(0, 0, '0, '0, 1, 0, 0, f);
      check_eq("stream_cnt", 32'(stall_cnt_o), 32'd0);
      check_eq("stream_drain", 32'(exp_q.size()), 32'd0);

      // Stall three cycles while 0xB is at the output
      step(0, 1, 16'h000A, 8'h0A, 1, 0, 0, f);
      step(0, 1, 16'h000B, 8'h0B, 1, 0, 0, f);
      c_sent = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step(0, !c_sent, 16'h000C, 8'h0C, 0, 0, 0, f);
         c_sent = c_sent | f;
      end
      check_eq("stall_cnt3", 32'(stall_cnt_o), 32'd3);
      for (int i = 0; i < 4; i++) begin
         step(0, !c_sent, 16'h000C, 8'h0C, 1, 0, 0, f);
         c_sent = c_sent | f;
      end
      check_eq("stall_sent", 32'(c_sent), 32'd1);
      check_eq("stall_drain", 32'(exp_q.size()), 32'd0);

      // Flush with both entries holding ctrl 0xFF
      step(0, 1, 16'h0011, 8'hFF, 0, 0, 1, f);
      step(0, 1, 16'h0022, 8'hFF, 0, 0, 0, f);
      step(0, 1, 16'h0033, 8'h5A, 0, 1, 0, f);
      check_eq("flush_valid", 32'(out_valid_o), 32'd0);
      check_eq("flush_ctrl", 32'(out_ctrl_o), 32'd0);
      for (int i = 0; i < 3; i++) step(0, 0, '0, '0, 1, 0, 0, f);

      // Counter saturation and clear-over-increment
      step(0, 1, 16'h0077, 8'h03, 0, 0, 1, f);
      for (int i = 0; i < 20; i++) step(0, 0, '0, '0, 0, 0, 0, f);
      check_eq("sat_15", 32'(stall_cnt_o), 32'd15);
      step(0, 0, '0, '0, 0, 0, 1, f);
      check_eq("sat_clr", 32'(stall_cnt_o), 32'd0);
      step(0, 0, '0, '0, 1, 0, 0, f);

      // Reset while FULL holding 0x55
      step(0, 1, 16'h0055, 8'h0F, 0, 0, 0, f);
      step(1, 1, 16'h0066, 8'h0E, 0, 0, 0, f);
      check_eq("mid_rst_valid", 32'(out_valid_o), 32'd0);
      check_eq("mid_rst_data", 32'(out_data_o), 32'd0);
      check_eq("mid_rst_ctrl", 32'(out_ctrl_o), 32'd0);
      step(1, 1, 16'h0066, 8'h0E, 1, 0, 0, f);
      step(0, 1, 16'h0099, 8'h21, 1, 0, 0, f);
      step(0, 0, '0, '0, 1, 0, 0, f);

      // Random traffic with occasional flush and clear
      for (int i = 0; i < 10000; i++) begin
         step(0, 1'($urandom_range(0, 1)), DW'($urandom_range(0, 65535)),
              CW'($urandom_range(0, 255)), ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 63) == 0), ($urandom_range(0, 127) == 0), f);
      end
      for (int i = 0; i < 4; i++) step(0, 0, '0, '0, 1, 0, 0, f);
      check_eq("final_drain", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised, handshaked pipeline stage register for the single-issue CPU pipeline. It replaces the fixed, always-loading inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) with one generic block. Each stage carries a data bundle and a control bundle under valid/ready flow control. The block supports stall (back-pressure), flush (bubble insertion with control zeroing), an optional 2-entry skid buffer and a saturating stall counter.

## Interface
Parameters:
- DATA_W, 128: width of the datapath bundle (PC, operands, immediate, register address).
- CTRL_W, 8: width of the control bundle (ALUOp, ALUSrc, Branch, MemRead, MemWrite, RegWrite, MemtoReg, …).
- CNT_W, 16: width of the stall counter.

Ports:
- clk_i, in, 1: clock; all state updates on its rising edge.
- rst_i, in, 1: reset, synchronous, active-high.
- in_valid_i, in, 1: upstream stage presents a valid bundle.
- in_ready_o, out, 1: this stage accepts the bundle this cycle.
- in_data_i, in, DATA_W: upstream data bundle.
- in_ctrl_i, in, CTRL_W: upstream control bundle.
- out_valid_o, out, 1: the stage holds a valid bundle.
- out_ready_i, in, 1: downstream stage consumes the bundle this cycle.
- out_data_o, out, DATA_W: registered data bundle.
- out_ctrl_o, out, CTRL_W: registered control bundle; all-zero whenever out_valid_o = 0.
- flush_i, in, 1: discard all held bundles (branch taken, exception).
- stall_cnt_o, out, CNT_W: saturating count of stalled cycles.
- stall_cnt_clr_i, in, 1: synchronous clear of stall_cnt_o.

## Operation
- in_fire = in_valid_i & in_ready_o. out_fire = out_valid_o & out_ready_i.
- The main entry drives out_*. The skid entry exists only when the skid buffer is compiled in.
- State machine (FSM shown for the skid build):
  - EMPTY: on in_fire, go to FULL and load main.
  - FULL: on in_fire & out_fire, stay in FULL and reload main. On in_fire & !out_fire, go to SKID and load skid. On !in_fire & out_fire, go to EMPTY. Otherwise hold.
  - SKID: in_ready_o = 0. On out_fire, go to FULL with main <= skid. Otherwise hold.
- Flush has priority over every other event:
  - Next state is EMPTY.
  - Both entries are invalidated.
  - out_ctrl_o is zeroed next cycle.
  - A bundle transferred on the flush cycle is dropped. The handshake completes but nothing is stored.
- Data in an invalid entry holds its last value (don't-care). Control in an invalid entry is forced to 0, so RegWrite and MemWrite can never leak from a bubble.
- Stall counter:
  - Increments by 1 each cycle with out_valid_o & !out_ready_i.
  - Saturates at 2^CNT_W−1; it does not wrap.
  - stall_cnt_clr_i has priority over increment. Clearing and incrementing in the same cycle yields 0.

## Timing
- Latency is 1 cycle: a bundle accepted at edge N appears on out_* after edge N.
- Throughput is 1 bundle per cycle while out_ready_i = 1.
- Reset values: out_valid_o = 0, out_data_o = 0, out_ctrl_o = 0, stall_cnt_o = 0, FSM in EMPTY. in_ready_o = 0 while rst_i = 1.
- Reset asserted mid-transfer: all held bundles are lost. The first acceptance is possible in the cycle after rst_i deasserts.
- Without the skid buffer, in_ready_o = !out_valid_o | out_ready_i. This is a combinational path from out_ready_i to in_ready_o.
- With the skid buffer, in_ready_o depends only on registered state (= state != SKID). The block therefore breaks the ready path.
- A simultaneous flush_i and rst_i behaves as reset.

## Configuration
- PIPE_STAGE_SKID_EN defined:
  - 2-entry buffer with the 3-state FSM above.
  - in_ready_o is registered.
  - A full-rate stream survives one cycle of out_ready_i = 0 with no bubble upstream.
- PIPE_STAGE_SKID_EN undefined:
  - Single entry with only the EMPTY and FULL states.
  - in_ready_o is combinational as given in Timing.
  - No skid storage is synthesised.
  - All other behaviour is identical: flush, control zeroing and the stall counter.

## Structure
- Package pipe_pkg holds:
  - The FSM state enum: EMPTY, FULL, SKID.
  - Control-bundle bit-position constants for ID/EX: ALUOP_LSB, ALUSRC_BIT, BRANCH_BIT, MEMREAD_BIT, MEMWRITE_BIT, REGWRITE_BIT, MEMTOREG_BIT.
  - CTRL_W_IDEX = 8.
- Sub-module sat_counter (parameter CNT_W; ports inc, clr, count) implements the stall counter.
- pipe_stage_reg is instantiated once per pipeline boundary, with DATA_W and CTRL_W set per stage.

## Test plan
- Reset then stream: hold rst_i for 2 cycles, then send data 0x1..0x5 back-to-back with out_ready_i = 1. Required: out_valid_o first rises 1 cycle after the first acceptance, out_data_o shows 1..5 on consecutive cycles, and stall_cnt_o = 0.
- Stall: stream 0xA, 0xB, 0xC and drop out_ready_i for 3 cycles while 0xB is at the output. Required:
  - Skid build: in_ready_o falls once skid holds 0xC.
  - No-skid build: in_ready_o = 0 for those 3 cycles.
  - No loss or duplication of bundles.
  - stall_cnt_o = 3.
- Flush: with the FSM in SKID (ctrl 0xFF in both entries), assert flush_i for 1 cycle with in_valid_i = 1. Required: next cycle out_valid_o = 0 and out_ctrl_o = 0x00, and the flush-cycle input is never output.
- Saturation: CNT_W = 4, 20 stalled cycles. Required: stall_cnt_o stops at 15. Asserting stall_cnt_clr_i together with a stall cycle gives stall_cnt_o = 0 next cycle.
- Reset mid-operation: with the FSM in FULL holding 0x55, assert rst_i. Required: next cycle out_valid_o = 0, out_data_o = 0, out_ctrl_o = 0, and in_ready_o = 0 while rst_i is high.
- Random valid/ready, 10k cycles against a scoreboard, run for both PIPE_STAGE_SKID_EN settings. Required: in-order delivery, no loss, and out_ctrl_o = 0 whenever out_valid_o = 0.
